// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: capture state encoding and default sizing shared by the PWM capture block.
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        S_CAP_IDLE,
        S_CAP_SYNC,
        S_CAP_HIGH,
        S_CAP_LOW
    } cap_state_e;

    localparam int unsigned DEFAULT_COUNT_WIDTH   = 32;
    localparam int unsigned DEFAULT_TIMEOUT_COUNT = 1000000;

endpackage

// File: rtl/pwm_capture_in_conditioner.sv
// pwm_in_conditioner: synchronizer, optional glitch filter (PWM_CAPTURE_GLITCH_FILTER_EN)
// and single-cycle rise/fall detection for the captured PWM input.
module pwm_in_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_bad_params
        $error("pwm_in_conditioner: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   filt_level;
    logic                   level_q, level_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);

    logic [FW-1:0] stable_cnt_q, stable_cnt_d;
    logic          filt_q, filt_d;

    // The filtered level only follows the synchronized level after FILTER_LEN differing cycles.
    always_comb begin
        stable_cnt_d = '0;
        filt_d       = filt_q;
        if (sync_q[SYNC_STAGES-1] != filt_q) begin
            if (stable_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = sync_q[SYNC_STAGES-1];
            end else begin
                stable_cnt_d = stable_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_cnt_q <= '0;
            filt_q       <= 1'b0;
        end else begin
            stable_cnt_q <= stable_cnt_d;
            filt_q       <= filt_d;
        end
    end

    assign filt_level = filt_q;
`else
    assign filt_level = sync_q[SYNC_STAGES-1];
`endif

    always_comb begin
        level_d = filt_level;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
        end
    end

    assign level = filt_level;
    assign rise  = filt_level & ~level_q;
    assign fall  = ~filt_level & level_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures ON time and period of pwm_in in clk cycles, with stuck-high/low timeout.
// Optional glitch filter on the input is enabled by defining PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH   = DEFAULT_COUNT_WIDTH,
    parameter int unsigned TIMEOUT_COUNT = DEFAULT_TIMEOUT_COUNT,
    parameter int          SYNC_STAGES   = 2,
    parameter int          FILTER_LEN    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   pwm_in,
    output logic [COUNT_WIDTH-1:0] T_on_measured,
    output logic [COUNT_WIDTH-1:0] T_period_measured,
    output logic                   meas_valid,
    output logic                   stuck_high,
    output logic                   stuck_low
);

    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_VAL = COUNT_WIDTH'(TIMEOUT_COUNT);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE     = COUNT_WIDTH'(1);

    logic level, rise, fall;

    pwm_in_conditioner #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_cond (
        .clk   (clk),
        .reset (reset),
        .pwm_in(pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    cap_state_e             state_q, state_d;
    logic [COUNT_WIDTH-1:0] period_cnt_q, period_cnt_d;
    logic [COUNT_WIDTH-1:0] on_cnt_q, on_cnt_d;
    logic [COUNT_WIDTH-1:0] t_on_q, t_on_d;
    logic [COUNT_WIDTH-1:0] t_period_q, t_period_d;
    logic                   meas_valid_q, meas_valid_d;
    logic                   stuck_high_q, stuck_high_d;
    logic                   stuck_low_q, stuck_low_d;
    logic                   timed_out, timeout_hit, timeout_high;

    // Using >= keeps a fall landing exactly on TIMEOUT_COUNT from letting the counter run on.
    assign timed_out = (period_cnt_q >= TIMEOUT_VAL);

    // NOTE: every variable gets its default first so no path through this block infers a latch.
    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        on_cnt_d     = on_cnt_q;
        t_on_d       = t_on_q;
        t_period_d   = t_period_q;
        meas_valid_d = 1'b0;
        stuck_high_d = stuck_high_q;
        stuck_low_d  = stuck_low_q;
        timeout_hit  = 1'b0;
        timeout_high = 1'b0;

        if (!enable) begin
            state_d      = S_CAP_IDLE;
            period_cnt_d = '0;
            on_cnt_d     = '0;
            stuck_high_d = 1'b0;
            stuck_low_d  = 1'b0;
        end else begin
            case (state_q)
                S_CAP_IDLE: begin
                    state_d      = S_CAP_SYNC;
                    period_cnt_d = CNT_ONE;
                end
                S_CAP_SYNC: begin
                    // Edges win over the timeout; a fall just proves the input is not stuck.
                    if (rise) begin
                        state_d      = S_CAP_HIGH;
                        period_cnt_d = CNT_ONE;
                        on_cnt_d     = CNT_ONE;
                    end else if (fall) begin
                        period_cnt_d = CNT_ONE;
                    end else if (timed_out) begin
                        timeout_hit  = 1'b1;
                        timeout_high = level;
                    end else begin
                        period_cnt_d = period_cnt_q + CNT_ONE;
                    end
                end
                S_CAP_HIGH: begin
                    if (fall) begin
                        state_d      = S_CAP_LOW;
                        period_cnt_d = period_cnt_q + CNT_ONE;
                    end else if (timed_out) begin
                        timeout_hit  = 1'b1;
                        timeout_high = 1'b1;
                    end else begin
                        period_cnt_d = period_cnt_q + CNT_ONE;
                        on_cnt_d     = on_cnt_q + CNT_ONE;
                    end
                end
                S_CAP_LOW: begin
                    if (rise) begin
                        state_d      = S_CAP_HIGH;
                        t_on_d       = on_cnt_q;
                        t_period_d   = period_cnt_q;
                        meas_valid_d = 1'b1;
                        stuck_high_d = 1'b0;
                        stuck_low_d  = 1'b0;
                        period_cnt_d = CNT_ONE;
                        on_cnt_d     = CNT_ONE;
                    end else if (timed_out) begin
                        timeout_hit = 1'b1;
                    end else begin
                        period_cnt_d = period_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_CAP_IDLE;
                end
            endcase

            if (timeout_hit) begin
                state_d      = S_CAP_SYNC;
                period_cnt_d = CNT_ONE;
                on_cnt_d     = '0;
                t_period_d   = TIMEOUT_VAL;
                t_on_d       = timeout_high ? TIMEOUT_VAL : '0;
                meas_valid_d = 1'b1;
                stuck_high_d = timeout_high;
                stuck_low_d  = ~timeout_high;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_CAP_IDLE;
            period_cnt_q <= '0;
            on_cnt_q     <= '0;
            t_on_q       <= '0;
            t_period_q   <= '0;
            meas_valid_q <= 1'b0;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            on_cnt_q     <= on_cnt_d;
            t_on_q       <= t_on_d;
            t_period_q   <= t_period_d;
            meas_valid_q <= meas_valid_d;
            stuck_high_q <= stuck_high_d;
            stuck_low_q  <= stuck_low_d;
        end
    end

    assign T_on_measured     = t_on_q;
    assign T_period_measured = t_period_q;
    assign meas_valid        = meas_valid_q;
    assign stuck_high        = stuck_high_q;
    assign stuck_low         = stuck_low_q;

endmodule
